// File: rtl/trace_pkg.sv
// Shared types and the trace character decode used by the scheduler and its benches.
package trace_pkg;

  // Playback states of the scheduler.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_t;

  // Largest trace the shared decode function can address, in characters.
  localparam int unsigned MaxLen       = 256;
  localparam int unsigned MaxTraceBits = MaxLen * 8;

  // The character that encodes a 1 in a trace string.
  localparam logic [7:0] HighChar = 8'h2d;  // "-"

  // Returns 1 when character idx of a len-character trace is "-".
  // The trace is right-aligned in the wide argument; character 0 is its most significant byte.
  function automatic logic trace_bit(input logic [MaxTraceBits-1:0] trace,
                                     input int unsigned             len,
                                     input int unsigned             idx);
    logic [7:0] ch;
    ch = trace[8*(len-1-idx) +: 8];
    return ch == HighChar;
  endfunction

endpackage

// File: rtl/trace_scheduler_if.sv
// Control and observation bundle between a bench sequencer and the trace scheduler.
interface trace_scheduler_if #(
  parameter int unsigned TW = 5
);

  logic          start;
  logic          pause;
  logic          step;
  logic          A;
  logic          B;
  logic          C;
  logic          D;
  logic [TW-1:0] t;
  logic          running;
  logic          done;

  // Sequencer side: drives playback controls, observes trace bits and status.
  modport master (
    output start, pause, step,
    input  A, B, C, D, t, running, done
  );

  // Scheduler side.
  modport slave (
    input  start, pause, step,
    output A, B, C, D, t, running, done
  );

endinterface

// File: rtl/trace_decode.sv
// Combinational lookup of one trace channel at the current time index.
module trace_decode
  import trace_pkg::*;
#(
  parameter int unsigned          LEN   = 32,
  parameter logic [LEN*8-1:0]     TRACE = {LEN{8'h5f}},
  localparam int unsigned         TW    = $clog2(LEN)
) (
  input  logic [TW-1:0] idx_i,
  output logic          bit_o
);

  // Widen the trace to the shared function's argument; right alignment keeps character order.
  localparam logic [MaxTraceBits-1:0] TraceExt = MaxTraceBits'(TRACE);

  // Zero-latency decode so the bit tracks the index in the same cycle.
  always_comb begin
    bit_o = trace_bit(TraceExt, LEN, 32'(idx_i));
  end

endmodule

// File: rtl/trace_scheduler.sv
// Playback sequencer for four character traces: idle, run, pause, single-step, one-shot or loop.
module trace_scheduler
  import trace_pkg::*;
#(
  parameter int unsigned      LEN     = 32,
  parameter logic [LEN*8-1:0] TRACE_A = {LEN{8'h5f}},
  parameter logic [LEN*8-1:0] TRACE_B = {LEN{8'h5f}},
  parameter logic [LEN*8-1:0] TRACE_C = {LEN{8'h5f}},
  parameter logic [LEN*8-1:0] TRACE_D = {LEN{8'h5f}},
  parameter bit               LOOP    = 1'b0,
  localparam int unsigned     TW      = $clog2(LEN)
) (
  input logic              clock,
  input logic              resetn,
  trace_scheduler_if.slave ctl
);

  // Explicit end-of-trace compare so LEN need not be a power of two.
  localparam logic [TW-1:0] TLast = TW'(LEN - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          running_q, done_q;
  logic          adv;

  // Next-state and next-index; adv requests one index step under the shared end-of-trace rule.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    adv     = 1'b0;
    unique case (state_q)
      StIdle: begin
        t_d = '0;
        if (ctl.start) state_d = StRun;
      end
      StRun: begin
        // pause wins over step and over advancing
        if (ctl.pause) state_d = StPause;
        else           adv     = 1'b1;
      end
      StPause: begin
        // leaving pause never advances, even with step high
        if (!ctl.pause)    state_d = StRun;
        else if (ctl.step) adv     = 1'b1;
      end
      StDone: begin
        t_d = TLast;
        if (ctl.start) begin
          state_d = StRun;
          t_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
        t_d     = '0;
      end
    endcase

    if (adv) begin
      if (t_q == TLast) begin
        if (LOOP) t_d     = '0;
        else      state_d = StDone;
      end else begin
        t_d = t_q + 1'b1;
      end
    end
  end

  // State, index and registered status decodes, with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= StIdle;
      t_q       <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  assign ctl.t       = t_q;
  assign ctl.running = running_q;
  assign ctl.done    = done_q;

  trace_decode #(
    .LEN   (LEN),
    .TRACE (TRACE_A)
  ) u_dec_a (
    .idx_i (t_q),
    .bit_o (ctl.A)
  );

  trace_decode #(
    .LEN   (LEN),
    .TRACE (TRACE_B)
  ) u_dec_b (
    .idx_i (t_q),
    .bit_o (ctl.B)
  );

  trace_decode #(
    .LEN   (LEN),
    .TRACE (TRACE_C)
  ) u_dec_c (
    .idx_i (t_q),
    .bit_o (ctl.C)
  );

  trace_decode #(
    .LEN   (LEN),
    .TRACE (TRACE_D)
  ) u_dec_d (
    .idx_i (t_q),
    .bit_o (ctl.D)
  );

endmodule

// File: tb/tb_trace_scheduler.sv
// Bench for trace_scheduler: a one-shot 32-character instance and a looping 20-character
// instance share stimulus and are compared every cycle against a behavioural model.
module tb_trace_scheduler;

  localparam int unsigned L0 = 32;
  localparam int unsigned L1 = 20;

  localparam int PhIdle  = 0;
  localparam int PhRun   = 1;
  localparam int PhPause = 2;
  localparam int PhDone  = 3;

  // Builds a len-character trace with "-" on characters lo..hi, character 0 most significant.
  function automatic logic [255:0] mk(input int len, input int lo, input int hi);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < len; i++) begin
      r[8*(len-1-i) +: 8] = (i >= lo && i <= hi) ? 8'h2d : 8'h5f;
    end
    return r;
  endfunction

  // Character ranges that hold "-" for each instance and channel (A, B, C, D).
  function automatic int lo_of(input int d, input int ch);
    int lo0 [4] = '{1, 2, 2, 7};
    int lo1 [4] = '{19, 0, 5, 0};
    return (d == 0) ? lo0[ch] : lo1[ch];
  endfunction

  function automatic int hi_of(input int d, input int ch);
    int hi0 [4] = '{1, 4, 6, 7};
    int hi1 [4] = '{19, 0, 10, 19};
    return (d == 0) ? hi0[ch] : hi1[ch];
  endfunction

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic start  = 1'b0;
  logic pause  = 1'b0;
  logic step   = 1'b0;

  always #5 clock = ~clock;

  trace_scheduler_if #(.TW(5)) if0 ();
  trace_scheduler_if #(.TW(5)) if1 ();

  assign if0.start = start;
  assign if0.pause = pause;
  assign if0.step  = step;
  assign if1.start = start;
  assign if1.pause = pause;
  assign if1.step  = step;

  trace_scheduler #(
    .LEN     (L0),
    .TRACE_A (mk(32, 1, 1)),
    .TRACE_B (mk(32, 2, 4)),
    .TRACE_C (mk(32, 2, 6)),
    .TRACE_D (mk(32, 7, 7)),
    .LOOP    (1'b0)
  ) u_dut0 (
    .clock  (clock),
    .resetn (resetn),
    .ctl    (if0)
  );

  trace_scheduler #(
    .LEN     (L1),
    .TRACE_A (160'(mk(20, 19, 19))),
    .TRACE_B (160'(mk(20, 0, 0))),
    .TRACE_C (160'(mk(20, 5, 10))),
    .TRACE_D (160'(mk(20, 0, 19))),
    .LOOP    (1'b1)
  ) u_dut1 (
    .clock  (clock),
    .resetn (resetn),
    .ctl    (if1)
  );

  int n_vec = 0;
  int n_bad = 0;

  int m_ph [2];
  int m_t  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One model step using the inputs sampled at this edge.
  task automatic model_step(input int d);
    int  len;
    bit  loop;
    bit  adv;
    len = (d == 0) ? L0 : L1;
    loop = (d == 1);
    adv = 1'b0;
    if (!resetn) begin
      m_ph[d] = PhIdle;
      m_t[d]  = 0;
    end else begin
      case (m_ph[d])
        PhIdle:  if (start) m_ph[d] = PhRun;
        PhRun:   if (pause) m_ph[d] = PhPause; else adv = 1'b1;
        PhPause: if (!pause) m_ph[d] = PhRun; else if (step) adv = 1'b1;
        default: if (start) begin m_ph[d] = PhRun; m_t[d] = 0; end
      endcase
      if (adv) begin
        if (!loop && m_t[d] == len - 1) m_ph[d] = PhDone;
        else                            m_t[d] = (m_t[d] + 1) % len;
      end
    end
  endtask

  // Advance one clock, update the model, then compare both instances away from the edge.
  task automatic cyc();
    logic [4:0] g_t   [2];
    logic       g_run [2];
    logic       g_dn  [2];
    logic       g_bit [2][4];
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    g_t[0] = if0.t;  g_run[0] = if0.running; g_dn[0] = if0.done;
    g_t[1] = if1.t;  g_run[1] = if1.running; g_dn[1] = if1.done;
    g_bit[0] = '{if0.A, if0.B, if0.C, if0.D};
    g_bit[1] = '{if1.A, if1.B, if1.C, if1.D};
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d.t", d), 32'(g_t[d]), 32'(m_t[d]));
      check_eq($sformatf("d%0d.running", d), 32'(g_run[d]), 32'(m_ph[d] == PhRun));
      check_eq($sformatf("d%0d.done", d), 32'(g_dn[d]), 32'(m_ph[d] == PhDone));
      for (int ch = 0; ch < 4; ch++) begin
        check_eq($sformatf("d%0d.bit%0d", d, ch), 32'(g_bit[d][ch]),
                 32'(m_t[d] >= lo_of(d, ch) && m_t[d] <= hi_of(d, ch)));
      end
    end
  endtask

  initial begin
    m_ph = '{PhIdle, PhIdle};
    m_t  = '{0, 0};

    // Reset, then a one-cycle start.
    resetn = 1'b0;
    repeat (2) cyc();
    resetn = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();

    // Pause for four cycles with two step pulses, then release.
    pause = 1'b1;
    cyc();
    step = 1'b1;
    repeat (2) cyc();
    step = 1'b0;
    cyc();
    pause = 1'b0;
    repeat (2) cyc();

    // Run the one-shot instance into DONE, restart, and try a second start while running.
    repeat (40) cyc();
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    repeat (10) cyc();

    // Pause mid-run, including pause with step in RUN, then reset while paused.
    pause = 1'b1;
    step  = 1'b1;
    cyc();
    step = 1'b0;
    repeat (3) cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    pause  = 1'b0;
    repeat (2) cyc();

    // Randomised control: occasional start/reset, slowly toggling pause, frequent steps.
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      step   = $urandom_range(0, 1);
      resetn = ($urandom_range(0, 199) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_scheduler.md
# trace_scheduler

Run-time controller for the trace-driven stimulus generator used by the SVA pass/fail benches. It owns the time index into four parameter-encoded character traces and sequences playback: idle, run, pause, single-step, one-shot completion or looping. Trace bits are decoded from the current index. It replaces the free-running saturating counter so a bench can hold, single-step or replay a scenario against `within`/repetition properties.

## Interface
- `LEN`, 32: trace length in characters, ≥2; index width `TW = $clog2(LEN)`.
- `TRACE_A`..`TRACE_D`, all `"_"` × LEN: `LEN*8`-bit strings. Character 0 is the leftmost (MSB) byte. `"-"` means 1; any other character means 0.
- `LOOP`, 0: 1 = wrap to index 0 after LEN-1; 0 = one-shot.
- `clock`  in  1  sole clock; all state changes on the posedge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  begin playback from IDLE or DONE.
- `pause`  in  1  level; hold the index while high.
- `step`  in  1  advance one index per cycle high, only while paused.
- `A`, `B`, `C`, `D`  out  1 each  decoded trace bits at index `t`.
- `t`  out  TW  current index.
- `running`  out  1  state is RUN.
- `done`  out  1  state is DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- **IDLE**
  - `t` = 0.
  - `start` → RUN. `t` stays 0 on the transition cycle; the first increment happens on the following edge.
- **RUN**
  - `pause` high → PAUSE; `t` does not increment on that edge.
  - Otherwise `t` increments.
  - At `t == LEN-1` with `pause` low:
    - `LOOP = 1`: `t` → 0, stay in RUN.
    - `LOOP = 0`: → DONE, `t` holds at LEN-1.
- **PAUSE**
  - `pause` low → RUN; `t` unchanged on the exit edge.
  - `pause` high and `step` high: `t` advances by one, using the same end-of-trace rule as RUN.
    - `LOOP = 0` at LEN-1: → DONE.
    - `LOOP = 1`: wrap to 0 and stay in PAUSE.
  - `step` outside PAUSE is ignored.
- **DONE**
  - `t` = LEN-1 and `done` = 1 until `start`.
  - `start` → RUN with `t` = 0 on the same edge.
- `start` is ignored in RUN and PAUSE.
- Decode is combinational from `t`:
  - `A = (TRACE_A[8*(LEN-1-t) +: 8] == "-")`; same pattern for B, C, D.
- Arithmetic: `t` is unsigned TW bits. Wrap and saturation are explicit comparisons against LEN-1; no reliance on natural overflow, so LEN need not be a power of two.

## Timing
- Reset, when `resetn` is low at a posedge, overrides every input and is valid mid-playback:
  - state IDLE, `t` = 0, `running` = 0, `done` = 0.
  - A–D show character 0 of each trace.
- `running` and `done` are registered state decodes; they change on the same edge as the state.
- A–D have zero latency from `t`: they change in the same cycle `t` changes.
- Simultaneous inputs:
  - In RUN, `pause` + `step` → PAUSE without advancing.
  - In PAUSE, `pause` low + `step` → RUN without advancing.

## Structure
- Package `trace_pkg` holds:
  - the `state_t` enum (IDLE, RUN, PAUSE, DONE);
  - the function `trace_bit(trace, len, idx)` implementing the `"-"` decode, shared with the bench sequencer.
- Sub-module `trace_decode #(LEN, TRACE)`: one instance per channel, combinational, index in, bit out.
- The top level contains only the FSM and the index register.

## Test plan
- Reset, then `start` held 1 cycle with `TRACE_A = "_-__…"`, `LOOP = 0`:
  - `t` reads 0,0,1,2,…,31 on successive cycles;
  - `A` = 1 only while `t` = 1;
  - `done` rises the cycle after `t` reaches 31 and stays set.
- Run to `t` = 5, assert `pause` for 4 cycles with `step` pulsed twice → `t` goes 5,5,6,7; release `pause` → `t` = 7, then 8.
- `LOOP = 1`, `LEN = 20`: sequence 18,19,0,1 with `running` held at 1 and `done` never set.
- In DONE, assert `start` → `t` = 0 and RUN on the same edge; a second `start` while running is ignored.
- Assert `resetn` low while in PAUSE at `t` = 12 → next cycle IDLE, `t` = 0, `running` = 0, `done` = 0.
- Drive the pass_05 traces (B `"__---…"`, C `"__-----…"`) and bind `A |=> (B[*3] within C[*]) ##1 D`:
  - holds during free run;
  - still holds with one PAUSE of 3 cycles inserted at `t` = 3, with a clock-gated property on `running`.
